// File: rtl/issue_unit.sv
// rtl/issue_unit.sv - FU dispatch side: instruction FIFO, single-outstanding issue/Comp handshake
// Optional completion watchdog built in when ISSUE_UNIT_TIMEOUT_EN is defined.
module issue_unit #(
    parameter int SIZE           = 32,
    parameter int REG_NUM        = 8,
    parameter int ALUOP_BITS     = 3,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ALUOP_BITS-1:0]      in_ALUOp,
    input  logic [$clog2(REG_NUM)-1:0] in_src_reg1,
    input  logic [$clog2(REG_NUM)-1:0] in_src_reg2,
    input  logic [$clog2(REG_NUM)-1:0] in_dest_reg1,
    input  logic                       in_use_imm,
    input  logic [SIZE-1:0]            in_imm,
    output logic [ALUOP_BITS-1:0]      ALUOp,
    output logic [$clog2(REG_NUM)-1:0] src_reg1,
    output logic [$clog2(REG_NUM)-1:0] src_reg2,
    output logic [$clog2(REG_NUM)-1:0] dest_reg1,
    output logic                       use_imm,
    output logic [SIZE-1:0]            imm,
    output logic                       issue,
    input  logic                       Comp,
    output logic                       busy,
    output logic [15:0]                comp_count,
    output logic                       timeout_err
);

    localparam int RW = $clog2(REG_NUM);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int EW = ALUOP_BITS + 3 * RW + 1 + SIZE;
    localparam logic [PW:0]   CNT_ONE = 1;
    localparam logic [PW-1:0] PTR_ONE = 1;

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    state_t                 state_q, state_d;
    logic [EW-1:0]          mem_q [FIFO_DEPTH];
    logic [EW-1:0]          mem_d [FIFO_DEPTH];
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [PW:0]            count_q, count_d;
    logic [ALUOP_BITS-1:0]  alu_op_q, alu_op_d;
    logic [RW-1:0]          src_reg1_q, src_reg1_d;
    logic [RW-1:0]          src_reg2_q, src_reg2_d;
    logic [RW-1:0]          dest_reg1_q, dest_reg1_d;
    logic                   use_imm_q, use_imm_d;
    logic [SIZE-1:0]        imm_q, imm_d;
    logic                   issue_q, issue_d;
    logic [15:0]            comp_count_q, comp_count_d;
    logic                   timeout_err_q, timeout_err_d;

    logic                   full;
    logic                   empty;
    logic                   push;
    logic                   pop;
    logic                   comp_ok;
    logic                   tmo_hit;
    logic                   done;
    logic [EW-1:0]          head;

`ifdef ISSUE_UNIT_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_ONE  = 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0]          tmo_cnt_q, tmo_cnt_d;
`else
    logic                   unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

    // FIFO_DEPTH is a power of two, so the count MSB alone marks full.
    assign full     = count_q[PW];
    assign empty    = (count_q == '0);
    assign push     = in_valid && !full;
    assign head     = mem_q[rd_ptr_q];
    assign in_ready = !full;

    // Comp in the issue cycle itself is not a completion of this instruction.
    assign comp_ok  = (state_q == WAIT) && Comp && !issue_q;
`ifdef ISSUE_UNIT_TIMEOUT_EN
    assign tmo_hit  = (state_q == WAIT) && !comp_ok && (tmo_cnt_q == TMO_LAST);
`else
    assign tmo_hit  = 1'b0;
`endif
    assign done     = comp_ok || tmo_hit;
    assign pop      = !empty && ((state_q == IDLE) || done);

    always_comb begin
        state_d       = state_q;
        mem_d         = mem_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        alu_op_d      = alu_op_q;
        src_reg1_d    = src_reg1_q;
        src_reg2_d    = src_reg2_q;
        dest_reg1_d   = dest_reg1_q;
        use_imm_d     = use_imm_q;
        imm_d         = imm_q;
        issue_d       = 1'b0;
        comp_count_d  = comp_count_q;
        timeout_err_d = timeout_err_q | tmo_hit;

        if (push) begin
            mem_d[wr_ptr_q] = {in_ALUOp, in_src_reg1, in_src_reg2, in_use_imm, in_imm, in_dest_reg1};
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end

        if (comp_ok) begin
            comp_count_d = comp_count_q + 16'd1;
        end

        if (pop) begin
            {alu_op_d, src_reg1_d, src_reg2_d, use_imm_d, imm_d, dest_reg1_d} = head;
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            issue_d  = 1'b1;
            state_d  = WAIT;
        end else if (done) begin
            state_d  = IDLE;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

`ifdef ISSUE_UNIT_TIMEOUT_EN
    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (pop) begin
            tmo_cnt_d = '0;
        end else if (state_q == WAIT) begin
            tmo_cnt_d = tmo_cnt_q + TMO_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`endif

    // Storage needs no reset: entries are only read behind the count.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            alu_op_q      <= '0;
            src_reg1_q    <= '0;
            src_reg2_q    <= '0;
            dest_reg1_q   <= '0;
            use_imm_q     <= 1'b0;
            imm_q         <= '0;
            issue_q       <= 1'b0;
            comp_count_q  <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            alu_op_q      <= alu_op_d;
            src_reg1_q    <= src_reg1_d;
            src_reg2_q    <= src_reg2_d;
            dest_reg1_q   <= dest_reg1_d;
            use_imm_q     <= use_imm_d;
            imm_q         <= imm_d;
            issue_q       <= issue_d;
            comp_count_q  <= comp_count_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign ALUOp       = alu_op_q;
    assign src_reg1    = src_reg1_q;
    assign src_reg2    = src_reg2_q;
    assign dest_reg1   = dest_reg1_q;
    assign use_imm     = use_imm_q;
    assign imm         = imm_q;
    assign issue       = issue_q;
    assign busy        = (state_q == WAIT);
    assign comp_count  = comp_count_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_issue_unit.sv
// tb/tb_issue_unit.sv - directed table-driven bench for issue_unit
module tb_issue_unit;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_ALUOp;
    logic [2:0]  in_src_reg1;
    logic [2:0]  in_src_reg2;
    logic [2:0]  in_dest_reg1;
    logic        in_use_imm;
    logic [31:0] in_imm;
    logic [2:0]  ALUOp;
    logic [2:0]  src_reg1;
    logic [2:0]  src_reg2;
    logic [2:0]  dest_reg1;
    logic        use_imm;
    logic [31:0] imm;
    logic        issue;
    logic        Comp;
    logic        busy;
    logic [15:0] comp_count;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;

`ifdef ISSUE_UNIT_TIMEOUT_EN
    localparam int EXP_IDLE_AT   = 65;
    localparam int EXP_TMO_ERR   = 1;
    localparam int EXP_CNT_AFTER = 6;
`else
    localparam int EXP_IDLE_AT   = 0;
    localparam int EXP_TMO_ERR   = 0;
    localparam int EXP_CNT_AFTER = 7;
`endif

    issue_unit #(
        .SIZE(32), .REG_NUM(8), .ALUOP_BITS(3), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(64)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_ALUOp(in_ALUOp), .in_src_reg1(in_src_reg1), .in_src_reg2(in_src_reg2),
        .in_dest_reg1(in_dest_reg1), .in_use_imm(in_use_imm), .in_imm(in_imm),
        .ALUOp(ALUOp), .src_reg1(src_reg1), .src_reg2(src_reg2), .dest_reg1(dest_reg1),
        .use_imm(use_imm), .imm(imm), .issue(issue), .Comp(Comp),
        .busy(busy), .comp_count(comp_count), .timeout_err(timeout_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        valid;
        logic        comp;
        logic [31:0] imm;
        logic        e_issue;
        logic        e_busy;
        logic        e_rdy;
        logic [31:0] e_imm;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    // Other instruction fields are derived from imm so one number names a whole instruction.
    function automatic logic [2:0] alu_of(input logic [31:0] v);
        return v[2:0] ^ 3'b010;
    endfunction
    function automatic logic [2:0] src1_of(input logic [31:0] v);
        return v[2:0] ^ 3'b010;
    endfunction
    function automatic logic [2:0] src2_of(input logic [31:0] v);
        return v[2:0];
    endfunction
    function automatic logic [2:0] dest_of(input logic [31:0] v);
        return v[2:0] + 3'd6;
    endfunction
    function automatic logic use_of(input logic [31:0] v);
        return ~v[0];
    endfunction

    function automatic void add(input logic valid, input logic comp, input logic [31:0] v,
                                input logic ei, input logic eb, input logic er,
                                input logic [31:0] eimm, input logic [15:0] ecnt);
        vec_t t;
        t.valid = valid; t.comp = comp; t.imm = v;
        t.e_issue = ei; t.e_busy = eb; t.e_rdy = er; t.e_imm = eimm; t.e_cnt = ecnt;
        vecs.push_back(t);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_instr(input logic valid, input logic [31:0] v);
        in_valid     = valid;
        in_imm       = v;
        in_ALUOp     = alu_of(v);
        in_src_reg1  = src1_of(v);
        in_src_reg2  = src2_of(v);
        in_dest_reg1 = dest_of(v);
        in_use_imm   = use_of(v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_issue"}, {31'd0, issue}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_rdy"}, {31'd0, in_ready}, 32'd1);
        check({tag, "_imm"}, imm, 32'd0);
        check({tag, "_fields"}, {20'd0, ALUOp, src_reg1, src_reg2, dest_reg1}, 32'd0);
        check({tag, "_use_imm"}, {31'd0, use_imm}, 32'd0);
        check({tag, "_cnt"}, {16'd0, comp_count}, 32'd0);
        check({tag, "_tmo"}, {31'd0, timeout_err}, 32'd0);
    endtask

    task automatic complete_one(input logic [31:0] v);
        drive_instr(1'b1, v);
        step();
        drive_instr(1'b0, 32'd0);
        step();
        check("c1_issue", {31'd0, issue}, 32'd1);
        step();
        Comp = 1'b1;
        step();
        Comp = 1'b0;
        check("c1_busy", {31'd0, busy}, 32'd0);
    endtask

    int idle_at;

    initial begin
        rst_n = 1'b0;
        Comp  = 1'b0;
        drive_instr(1'b0, 32'd0);

        // Reset + single instruction, FIFO fill/drain, ignored Comps.
        add(1, 0, 10, 0, 0, 1,  0, 0);
        add(0, 0,  0, 1, 1, 1, 10, 0);
        add(0, 0,  0, 0, 1, 1, 10, 0);
        add(0, 0,  0, 0, 1, 1, 10, 0);
        add(0, 1,  0, 0, 0, 1, 10, 1);
        add(0, 1,  0, 0, 0, 1, 10, 1);
        add(1, 0,  1, 0, 0, 1, 10, 1);
        add(1, 0,  2, 1, 1, 1,  1, 1);
        add(1, 1,  3, 0, 1, 1,  1, 1);
        add(1, 0,  4, 0, 1, 1,  1, 1);
        add(1, 0,  5, 0, 1, 0,  1, 1);
        add(1, 0,  6, 0, 1, 0,  1, 1);
        add(0, 1,  0, 1, 1, 1,  2, 2);
        add(0, 1,  0, 0, 1, 1,  2, 2);
        add(0, 1,  0, 1, 1, 1,  3, 3);
        add(0, 0,  0, 0, 1, 1,  3, 3);
        add(0, 1,  0, 1, 1, 1,  4, 4);
        add(0, 0,  0, 0, 1, 1,  4, 4);
        add(0, 1,  0, 1, 1, 1,  5, 5);
        add(0, 0,  0, 0, 1, 1,  5, 5);
        add(0, 1,  0, 0, 0, 1,  5, 6);

        #12;
        check_zero_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        step();

        foreach (vecs[i]) begin
            drive_instr(vecs[i].valid, vecs[i].imm);
            Comp = vecs[i].comp;
            step();
            check($sformatf("v%0d_issue", i), {31'd0, issue}, {31'd0, vecs[i].e_issue});
            check($sformatf("v%0d_busy", i), {31'd0, busy}, {31'd0, vecs[i].e_busy});
            check($sformatf("v%0d_rdy", i), {31'd0, in_ready}, {31'd0, vecs[i].e_rdy});
            check($sformatf("v%0d_imm", i), imm, vecs[i].e_imm);
            check($sformatf("v%0d_cnt", i), {16'd0, comp_count}, {16'd0, vecs[i].e_cnt});
            if (vecs[i].e_imm != 32'd0) begin
                check($sformatf("v%0d_fields", i),
                      {19'd0, ALUOp, src_reg1, src_reg2, dest_reg1, use_imm},
                      {19'd0, alu_of(vecs[i].e_imm), src1_of(vecs[i].e_imm), src2_of(vecs[i].e_imm),
                       dest_of(vecs[i].e_imm), use_of(vecs[i].e_imm)});
            end else begin
                check($sformatf("v%0d_fields", i),
                      {19'd0, ALUOp, src_reg1, src_reg2, dest_reg1, use_imm}, 32'd0);
            end
        end
        drive_instr(1'b0, 32'd0);
        Comp = 1'b0;

        // Watchdog: FU never completes.
        drive_instr(1'b1, 32'd20);
        step();
        drive_instr(1'b0, 32'd0);
        idle_at = 0;
        for (int i = 1; i <= 70; i++) begin
            step();
            if (!busy && idle_at == 0) idle_at = i;
        end
        check("tmo_idle_at", idle_at, EXP_IDLE_AT);
        check("tmo_err", {31'd0, timeout_err}, EXP_TMO_ERR);
        check("tmo_busy", {31'd0, busy}, (EXP_IDLE_AT == 0) ? 32'd1 : 32'd0);
        Comp = 1'b1;
        step();
        Comp = 1'b0;
        check("tmo_cnt_after", {16'd0, comp_count}, EXP_CNT_AFTER);
        check("tmo_err_sticky", {31'd0, timeout_err}, EXP_TMO_ERR);
        check("tmo_busy_after", {31'd0, busy}, 32'd0);

        // Counter wrap from a preset near the top.
        dut.comp_count_q = 16'hFFFE;
        complete_one(32'd30);
        check("wrap_ffff", {16'd0, comp_count}, 32'h0000FFFF);
        complete_one(32'd31);
        check("wrap_zero", {16'd0, comp_count}, 32'h00000000);

        // Asynchronous reset while WAITing with two queued.
        drive_instr(1'b1, 32'd40);
        step();
        drive_instr(1'b1, 32'd41);
        step();
        drive_instr(1'b1, 32'd42);
        step();
        drive_instr(1'b0, 32'd0);
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        check("pre_rst_imm", imm, 32'd40);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero_outputs("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        step();
        Comp = 1'b1;
        step();
        Comp = 1'b0;
        check("post_rst_cnt", {16'd0, comp_count}, 32'd0);
        check("post_rst_busy", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("post_rst_idle%0d", i), {30'd0, busy, issue}, 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/issue_unit.md
ISSUE_UNIT -- requirements
Module: issue_unit

Interface
REQ-001 Parameters SHALL be: SIZE, 32, data/immediate width; REG_NUM, 8, register count; ALUOP_BITS, 3, ALU opcode width; FIFO_DEPTH, 4, queued instructions (power of 2); TIMEOUT_CYCLES, 64, completion watchdog limit.
REQ-002 Ports SHALL be, in order:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  instruction offered
- in_ready  out  1  instruction accepted when in_valid&in_ready at edge
- in_ALUOp  in  ALUOP_BITS  queued opcode
- in_src_reg1, in_src_reg2, in_dest_reg1  in  $clog2(REG_NUM) each  queued register indices
- in_use_imm  in  1  queued immediate select
- in_imm  in  SIZE  queued immediate
- ALUOp  out  ALUOP_BITS  opcode to FU
- src_reg1, src_reg2, dest_reg1  out  $clog2(REG_NUM) each  register indices to FU
- use_imm  out  1  immediate select to FU
- imm  out  SIZE  immediate to FU
- issue  out  1  one-cycle issue strobe to FU
- Comp  in  1  one-cycle completion strobe from FU
- busy  out  1  instruction in flight
- comp_count  out  16  completed-instruction counter
- timeout_err  out  1  sticky watchdog flag

Function
REQ-003 Block SHALL be the dispatch side of the FU issue/Comp protocol: queue instructions, issue one at a time, wait for Comp.
REQ-004 Queue SHALL be a FIFO of FIFO_DEPTH entries holding {ALUOp, src_reg1, src_reg2, use_imm, imm, dest_reg1}; in_ready SHALL equal !full.
REQ-005 Push while full SHALL be impossible (in_ready low); push and pop in the same edge when not full SHALL both occur, occupancy unchanged; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-006 FSM states SHALL be IDLE and WAIT only.
REQ-007 IDLE with FIFO non-empty: at the edge, pop head into FU output registers, drive issue=1 for exactly the following cycle, go to WAIT.
REQ-008 Latency: instruction pushed into an empty FIFO at edge k SHALL pop at edge k+1 with issue high from edge k+1 to edge k+2.
REQ-009 FU output fields SHALL be held stable from pop until the Comp that retires the instruction, and until the next pop thereafter.
REQ-010 busy SHALL equal (state==WAIT).
REQ-011 In WAIT, Comp=1 while issue=0 SHALL retire the instruction: comp_count+1 (wraps 0xFFFF->0x0000); if FIFO non-empty, pop and re-issue at that same edge (back-to-back, issue high next cycle, stay WAIT), else go IDLE.
REQ-012 Comp while issue=1, or in IDLE, SHALL be ignored (no count, no state change).
REQ-013 issue SHALL never be high for two consecutive cycles.

Reset
REQ-014 rst_n low SHALL immediately, independent of clk: state=IDLE, FIFO empty, all FU outputs 0, issue=0, busy=0, comp_count=0, timeout_err=0; in_ready=1 once FIFO empty.
REQ-015 Reset mid-operation SHALL abandon the in-flight and queued instructions; a Comp arriving after reset release SHALL be ignored per REQ-012.

Configuration
REQ-016 Macro ISSUE_UNIT_TIMEOUT_EN defined: cycle counter cleared on each issue, increments each WAIT cycle; reaching TIMEOUT_CYCLES without Comp SHALL set timeout_err (sticky until reset), abandon the instruction without counting, and leave WAIT via the REQ-011 next-state rule.
REQ-017 Macro undefined: no counter, timeout_err tied 0, WAIT persists until Comp.

Verification
REQ-018 Reset, push {ALUOp=0, src1=0, use_imm=1, imm=10, dest=0} at edge k -> issue high k+1..k+2, imm=10, busy=1; Comp 3 cycles later -> busy=0, comp_count=1.
REQ-019 Push 5 back-to-back while FU withholds Comp -> first issues, next 4 fill FIFO, in_ready=0 after the 5th accept; each Comp triggers next issue at same edge; comp_count=5 at end.
REQ-020 Comp during issue cycle and Comp in IDLE -> ignored, comp_count unchanged, state unchanged.
REQ-021 rst_n low mid-WAIT with 2 queued -> all outputs 0 asynchronously, FIFO empty; post-release Comp -> comp_count stays 0.
REQ-022 ISSUE_UNIT_TIMEOUT_EN, TIMEOUT_CYCLES=64, no Comp -> timeout_err=1 after 64 WAIT cycles, busy=0, comp_count=0; undefined -> busy stays 1, timeout_err=0.
REQ-023 comp_count preset path via 65536 completions -> wraps to 0x0000.
